// File: rtl/icache_refill.sv
// Direct-mapped, one-word-per-line instruction cache. Hits are served in the
// same cycle; misses are refilled as four little-endian byte reads from the memory port.
module icache_refill #(
  parameter int INDEX_BITS = 7,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  flush_i,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_pc_i,
  input  logic                  if_cancel_i,
  output logic                  if_valid_o,
  output logic [31:0]           if_inst_o,
  output logic                  hit_o,
  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [7:0]            mem_byte_i
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_WIDTH - INDEX_BITS - 2;

  typedef enum logic [1:0] {IDLE, FILL, RESP} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-3:0]   fill_line;
  logic [2:0]              issue_cnt;
  logic [2:0]              cap_cnt;
  logic                    inflight;
  logic [1:0]              inflight_slot;
  logic [31:0]             fill_word;
  logic [LINES-1:0]        valid_q;
  logic [TAG_W-1:0]        tag_mem  [LINES];
  logic [31:0]             data_mem [LINES];

  logic [INDEX_BITS-1:0]   req_idx, fill_idx;
  logic [TAG_W-1:0]        req_tag, fill_tag;
  logic                    abort, lookup_hit, start_fill, grant, last_capture, commit;
  logic                    unused_offset;

  assign req_idx       = if_pc_i[INDEX_BITS+1:2];
  assign req_tag       = if_pc_i[ADDR_WIDTH-1:INDEX_BITS+2];
  assign fill_idx      = fill_line[INDEX_BITS-1:0];
  assign fill_tag      = fill_line[ADDR_WIDTH-3:INDEX_BITS];
  assign unused_offset = ^if_pc_i[1:0];

  // A flush in the same cycle as a lookup forces a miss and blocks a new fill.
  assign abort        = if_cancel_i | flush_i;
  assign lookup_hit   = if_req_i & valid_q[req_idx] & (tag_mem[req_idx] == req_tag) & ~flush_i;
  assign start_fill   = (state == IDLE) & if_req_i & ~lookup_hit & ~flush_i;
  assign grant        = mem_req_o & mem_gnt_i;
  assign last_capture = inflight & (cap_cnt == 3'd3);
  assign commit       = (state == RESP) & ~abort;
  assign mem_addr_o   = {fill_line, issue_cnt[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     state <= IDLE;
    else if (rdy) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_fill) state_nxt = FILL;
      FILL:    if (abort) state_nxt = IDLE;
               else if (last_capture) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_line     <= '0;
      issue_cnt     <= '0;
      cap_cnt       <= '0;
      inflight      <= 1'b0;
      inflight_slot <= '0;
      fill_word     <= '0;
      valid_q       <= '0;
    end else if (rdy) begin
      if (flush_i)     valid_q <= '0;
      else if (commit) valid_q[fill_idx] <= 1'b1;

      if (start_fill) begin
        fill_line <= if_pc_i[ADDR_WIDTH-1:2];
        issue_cnt <= '0;
        cap_cnt   <= '0;
        inflight  <= 1'b0;
      end else if (state == FILL && !abort) begin
        inflight <= grant;
        if (grant) begin
          issue_cnt     <= issue_cnt + 3'd1;
          inflight_slot <= issue_cnt[1:0];
        end
        if (inflight) begin
          fill_word[8*inflight_slot +: 8] <= mem_byte_i;
          cap_cnt                         <= cap_cnt + 3'd1;
        end
      end else begin
        inflight <= 1'b0;
      end
    end
  end

  // NOTE: tag/data arrays carry no reset; the reset valid bits alone make their contents harmless.
  always_ff @(posedge clk) begin
    if (rdy && commit) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= fill_word;
    end
  end

  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    if_valid_o = 1'b0;
    if_inst_o  = '0;
    hit_o      = 1'b0;
    mem_req_o  = 1'b0;
    case (state)
      IDLE: begin
        hit_o      = lookup_hit;
        if_valid_o = lookup_hit;
        if (lookup_hit) if_inst_o = data_mem[req_idx];
      end
      FILL: mem_req_o = ~issue_cnt[2];
      RESP: begin
        if_valid_o = ~abort;
        if (!abort) if_inst_o = fill_word;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_icache_refill.sv
// Scoreboard bench for icache_refill: a byte RAM model answers the memory port,
// expected words are queued at request time and popped when if_valid_o appears.
module tb_icache_refill;

  logic        clk = 1'b0;
  logic        rst, rdy, flush_i, if_req_i, if_cancel_i, mem_gnt_i;
  logic [31:0] if_pc_i;
  logic        if_valid_o, hit_o, mem_req_o;
  logic [31:0] if_inst_o, mem_addr_o;
  logic [7:0]  mem_byte_i = 8'h00;

  logic [7:0]  ram [65536];
  int          granted = 0;
  logic [31:0] sb [$];
  int          vectors = 0;
  int          miscompares = 0;

  icache_refill #(.INDEX_BITS(7), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush_i(flush_i),
    .if_req_i(if_req_i), .if_pc_i(if_pc_i), .if_cancel_i(if_cancel_i),
    .if_valid_o(if_valid_o), .if_inst_o(if_inst_o), .hit_o(hit_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
    .mem_byte_i(mem_byte_i)
  );

  always #5 clk = ~clk;

  // Byte RAM: the byte addressed under grant appears on mem_byte_i the next cycle.
  always @(posedge clk) begin
    if (rdy && mem_req_o && mem_gnt_i) begin
      mem_byte_i <= ram[mem_addr_o[15:0]];
      granted    <= granted + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    logic [15:0] a;
    a = {pc[15:2], 2'b00};
    return {ram[a + 16'd3], ram[a + 16'd2], ram[a + 16'd1], ram[a]};
  endfunction

  // Fetch one instruction; latency is 0 on a hit, else 6 plus every stalled cycle.
  task automatic fetch(input logic [31:0] pc, input bit exp_hit,
                       input int drop_at, input int drop_len, input int rdy_at);
    int base, cyc, extra, dropped;
    bit done;
    logic [31:0] exp;
    sb.push_back(word_at(pc));
    base = granted; cyc = 0; extra = 0; dropped = 0; done = 0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      if_req_i  = 1'b1;
      if_pc_i   = pc;
      rdy       = !(rdy_at >= 0 && cyc >= rdy_at && cyc < rdy_at + 4);
      mem_gnt_i = 1'b1;
      if (granted - base == drop_at && dropped < drop_len) begin
        mem_gnt_i = 1'b0;
        dropped++;
      end
      #1;
      if (!rdy || (mem_req_o && !mem_gnt_i)) extra++;
      if (mem_req_o) check("mem_addr", mem_addr_o, {pc[31:2], 2'(granted - base)});
      if (if_valid_o) begin
        done = 1;
        exp  = sb.pop_front();
        check("inst", if_inst_o, exp);
        check("hit", {31'b0, hit_o}, {31'b0, exp_hit});
        check("latency", cyc, exp_hit ? 0 : 6 + extra);
        if (exp_hit) check("no_mem_req_on_hit", {31'b0, mem_req_o}, 32'd0);
      end
      cyc++;
    end
    if (!done) begin
      check("valid_timeout", {31'b0, if_valid_o}, 32'd1);
      void'(sb.pop_front());
    end
    @(negedge clk);
    if_req_i = 1'b0; rdy = 1'b1; mem_gnt_i = 1'b1;
  endtask

  // Start a fill and abandon it once two bytes have been granted.
  task automatic cancel_fill(input logic [31:0] pc);
    int base, cyc;
    bit sent;
    base = granted; cyc = 0; sent = 0;
    while (!sent && cyc < 20) begin
      @(negedge clk);
      if_req_i = 1'b1; if_pc_i = pc; mem_gnt_i = 1'b1;
      if (granted - base == 2) begin
        if_cancel_i = 1'b1;
        sent = 1;
      end
      #1;
      check("no_valid_before_cancel", {31'b0, if_valid_o}, 32'd0);
      cyc++;
    end
    @(negedge clk);
    if_req_i = 1'b0; if_cancel_i = 1'b0;
    #1;
    check("req_drop_after_cancel", {31'b0, mem_req_o}, 32'd0);
    repeat (6) begin
      @(negedge clk); #1;
      check("no_valid_after_cancel", {31'b0, if_valid_o}, 32'd0);
    end
  endtask

  // Run a miss with continuous grant and flush in its RESP cycle (cycle 6).
  task automatic resp_flush(input logic [31:0] pc);
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      if_req_i = 1'b1; if_pc_i = pc; mem_gnt_i = 1'b1;
      flush_i  = (c == 6);
      #1;
      check("no_valid_flush_resp", {31'b0, if_valid_o}, 32'd0);
    end
    @(negedge clk);
    if_req_i = 1'b0; flush_i = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'(i * 29 + (i >> 8) * 7 + 3);
    ram[0] = 8'h13; ram[1] = 8'h04; ram[2] = 8'h61; ram[3] = 8'hFF;

    rst = 1'b0; rdy = 1'b1; flush_i = 1'b0; if_req_i = 1'b0; if_cancel_i = 1'b0;
    mem_gnt_i = 1'b1; if_pc_i = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_if_valid", {31'b0, if_valid_o}, 32'd0);
    check("rst_if_inst", if_inst_o, 32'd0);
    check("rst_hit", {31'b0, hit_o}, 32'd0);
    check("rst_mem_req", {31'b0, mem_req_o}, 32'd0);
    check("rst_mem_addr", mem_addr_o, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    fetch(32'h0000_0000, 0, -1, 0, -1);
    fetch(32'h0000_0000, 1, -1, 0, -1);

    fetch(32'h0000_1000, 0, 2, 3, -1);

    fetch(32'h0000_0200, 0, -1, 0, -1);
    fetch(32'h0000_0000, 0, -1, 0, -1);
    fetch(32'h0000_0000, 1, -1, 0, -1);

    cancel_fill(32'h0000_0040);
    fetch(32'h0000_0040, 0, -1, 0, -1);

    fetch(32'h0000_0084, 0, -1, 0, -1);
    fetch(32'h0000_0040, 1, -1, 0, -1);
    fetch(32'h0000_0000, 1, -1, 0, -1);
    @(negedge clk);
    if_req_i = 1'b1; if_pc_i = 32'h0000_0084; flush_i = 1'b1;
    #1;
    check("flush_lookup_hit", {31'b0, hit_o}, 32'd0);
    check("flush_lookup_valid", {31'b0, if_valid_o}, 32'd0);
    @(negedge clk);
    if_req_i = 1'b0; flush_i = 1'b0;
    #1;
    check("flush_no_fill", {31'b0, mem_req_o}, 32'd0);
    fetch(32'h0000_0000, 0, -1, 0, -1);
    fetch(32'h0000_0040, 0, -1, 0, -1);
    fetch(32'h0000_0084, 0, -1, 0, -1);

    resp_flush(32'h0000_02C8);
    fetch(32'h0000_02C8, 0, -1, 0, -1);

    fetch(32'h0000_3000, 0, -1, 0, 3);
    fetch(32'h0000_3000, 1, -1, 0, -1);

    repeat (3) begin
      @(negedge clk);
      if_req_i = 1'b1; if_pc_i = 32'h0000_0080;
    end
    #1 rst = 1'b0;
    #1;
    check("rst_mid_fill_req", {31'b0, mem_req_o}, 32'd0);
    check("rst_mid_fill_addr", mem_addr_o, 32'd0);
    check("rst_mid_fill_valid", {31'b0, if_valid_o}, 32'd0);
    @(negedge clk);
    if_req_i = 1'b0; rst = 1'b1;
    fetch(32'h0000_3000, 0, -1, 0, -1);
    fetch(32'h0000_0084, 0, -1, 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
